divider_controller: RTL and testbench
=====================================

DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with the ports named as the codebase names them.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port inp, input, 8 bits: operand byte from the switches.
REQ-005 Port set, input, 1 bit: button that loads the byte on inp.
REQ-006 Port unlock, input, 1 bit: button that re-arms set.
REQ-007 Port select, input, 2 bits: chooses which result byte drives out.
REQ-008 Port out, output, 8 bits: the selected result byte.
REQ-009 Ports setled, unlockled, select0led and select1led, outputs, 1 bit each: SHALL be direct combinational copies of set, unlock, select[0] and select[1].
REQ-010 Port busyled, output, 1 bit: high while a division is running.
REQ-011 Port doneled, output, 1 bit: high while a valid result is held.
REQ-012 Port errled, output, 1 bit: high when the last division had a zero divisor.

Function
REQ-013 Byte loading SHALL be accepted only in state IDLE, and only when set=1 and lock=0.
- An accepted load writes inp into the slot chosen by a 2-bit counter:
- 00 -> dividend[7:0], 01 -> dividend[15:8], 10 -> divisor[7:0], 11 -> divisor[15:8].
- It then increments the counter and sets lock=1.
REQ-014 lock SHALL clear on any cycle with unlock=1 and no accepted set; set held high SHALL load exactly one byte.
REQ-015 If set=1 and unlock=1 in the same cycle while lock=0, the load SHALL be accepted and lock SHALL end at 1.
REQ-016 The FSM SHALL have the states IDLE, DIVIDE and DONE.
- IDLE -> DIVIDE on the edge that accepts the byte in slot 11; the counter wraps to 00.
- DIVIDE -> DONE after exactly 16 iteration edges.
- DONE -> IDLE on the next accepted set; that set's byte is also loaded into slot 00.
REQ-017 Division SHALL be unsigned restoring division, 16-bit dividend by 16-bit divisor, one quotient bit per cycle, MSB first, using a 17-bit partial remainder.
REQ-018 Latency: if the last byte is accepted at edge E, the quotient and remainder registers and doneled SHALL update at edge E+16.
REQ-019 A divisor of 0 SHALL still take 16 cycles and SHALL give quotient=16'hFFFF, remainder=dividend and errled=1. errled clears when the next division starts.
REQ-020 Result registers SHALL hold the previous result during DIVIDE; working registers SHALL be separate from them.
REQ-021 out SHALL be combinational on select:
- 00 -> quotient[7:0], 01 -> quotient[15:8], 10 -> remainder[7:0], 11 -> remainder[15:8].
REQ-022 set SHALL be ignored during DIVIDE (no load, no counter change, lock unchanged); unlock SHALL still clear lock.
REQ-023 busyled SHALL be 1 exactly in DIVIDE; doneled SHALL be 1 exactly in DONE.

Reset
REQ-024 On rst_n=0 the block SHALL immediately force:
- state=IDLE, counter=00, lock=0;
- dividend, divisor, quotient and remainder = 0, plus the working registers;
- out=8'h00, busyled=0, doneled=0, errled=0.
REQ-025 Reset asserted mid-DIVIDE SHALL abort the division and leave no partial result visible.
REQ-026 The first edge after rst_n rises SHALL behave as a normal IDLE cycle.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration, OPW=16 and BYTEW=8, and the select encodings.
REQ-028 One sub-module, divider_core, SHALL implement the iterative restoring datapath with ports start, dividend, divisor, busy, done, quotient and remainder; divider_controller SHALL own loading, lock, select and LEDs.

Verification
REQ-029 Load 8'hE8, 8'h03, 8'h07, 8'h00 (1000 / 7) with set/unlock pulses -> 16 cycles after the 4th load, quotient=16'h008E and remainder=16'h0006; select=00 gives out=8'h8E, select=10 gives out=8'h06; doneled=1.
REQ-030 Dividend 16'hFFFF, divisor 16'h0001 -> quotient=16'hFFFF, remainder=0; select=01 gives out=8'hFF.
REQ-031 Dividend 16'h1234, divisor 0 -> quotient=16'hFFFF, remainder=16'h1234, errled=1; the next valid division clears errled.
REQ-032 Hold set high 10 cycles, then unlock, then set -> exactly two bytes loaded; set pulses during busyled=1 -> no change to operands or counter.
REQ-033 Assert rst_n=0 at cycle 8 of a division -> all outputs 0 and state IDLE; a subsequent 1000 / 7 load gives the REQ-029 result.

Source files
------------

// File: rtl/divider_controller_pkg.sv
// Shared types and widths for the switch-driven 16/16 divider controller.
package divider_controller_pkg;

   localparam int unsigned OPW   = 16;
   localparam int unsigned BYTEW = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Which result byte drives the display
   typedef enum logic [1:0] {
      SEL_QUO_LO = 2'b00,
      SEL_QUO_HI = 2'b01,
      SEL_REM_LO = 2'b10,
      SEL_REM_HI = 2'b11
   } sel_e;

   // Operand byte slot addressed by the load counter
   typedef enum logic [1:0] {
      SLOT_DVD_LO = 2'b00,
      SLOT_DVD_HI = 2'b01,
      SLOT_DVS_LO = 2'b10,
      SLOT_DVS_HI = 2'b11
   } slot_e;

endpackage

// File: rtl/divider_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
module divider_core
   import divider_controller_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [OPW-1:0] dividend,
   input  logic [OPW-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic [OPW-1:0] quotient,
   output logic [OPW-1:0] remainder
);

   localparam int unsigned CNTW = $clog2(OPW);

   logic            busy_q, busy_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [OPW-1:0]  rem_q, rem_d;
   logic [OPW-1:0]  quo_q, quo_d;
   logic [OPW-1:0]  dvs_q, dvs_d;
   logic [OPW-1:0]  quotient_q, quotient_d;
   logic [OPW-1:0]  remainder_q, remainder_d;

   logic [OPW:0]    part;
   logic [OPW-1:0]  trial;
   logic            ge;

   always_comb begin
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      // 17-bit partial remainder; when it covers the divisor the true
      // difference is below the divisor, so the low 16 bits are exact
      part  = {rem_q, quo_q[OPW-1]};
      ge    = (part >= {1'b0, dvs_q});
      trial = part[OPW-1:0] - dvs_q;
      done  = busy_q && (cnt_q == CNTW'(OPW - 1));

      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = dividend;
         dvs_d  = divisor;
      end else if (busy_q) begin
         rem_d = ge ? trial : part[OPW-1:0];
         quo_d = {quo_q[OPW-2:0], ge};
         cnt_d = cnt_q + CNTW'(1);
         if (done) begin
            busy_d      = 1'b0;
            quotient_d  = quo_d;
            remainder_d = rem_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy      = busy_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: rtl/divider_controller.sv
// Button/switch front end: loads operand bytes, sequences the divider, drives LEDs.
module divider_controller
   import divider_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BYTEW-1:0] inp,
   input  logic             set,
   input  logic             unlock,
   input  logic [1:0]       select,
   output logic [BYTEW-1:0] out,
   output logic             setled,
   output logic             unlockled,
   output logic             select0led,
   output logic             select1led,
   output logic             busyled,
   output logic             doneled,
   output logic             errled
);

   state_e         state_q, state_d;
   slot_e          cnt_q, cnt_d;
   logic           lock_q, lock_d;
   logic           err_q, err_d;
   logic [OPW-1:0] dividend_q, dividend_d;
   logic [OPW-1:0] divisor_q, divisor_d;

   logic           accept;
   logic           start;
   logic           core_busy;
   logic           core_done;
   logic [OPW-1:0] quotient;
   logic [OPW-1:0] remainder;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      err_d      = err_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      start      = 1'b0;

      // A load from DONE lands in slot 00 because the counter wrapped on start
      accept = set && !lock_q && (state_q != ST_DIVIDE);

      if (accept) begin
         lock_d = 1'b1;
         cnt_d  = slot_e'(cnt_q + 2'd1);
         unique case (cnt_q)
            SLOT_DVD_LO: dividend_d[BYTEW-1:0]   = inp;
            SLOT_DVD_HI: dividend_d[OPW-1:BYTEW] = inp;
            SLOT_DVS_LO: divisor_d[BYTEW-1:0]    = inp;
            SLOT_DVS_HI: divisor_d[OPW-1:BYTEW]  = inp;
            default:     ;
         endcase
      end else if (unlock) begin
         lock_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept && (cnt_q == SLOT_DVS_HI)) begin
               state_d = ST_DIVIDE;
               start   = 1'b1;
               err_d   = 1'b0;
            end
         end
         ST_DIVIDE: begin
            if (core_done) begin
               state_d = ST_DONE;
               err_d   = (divisor_q == '0);
            end
         end
         ST_DONE: begin
            if (accept) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= SLOT_DVD_LO;
         lock_q     <= 1'b0;
         err_q      <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         err_q      <= err_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
      end
   end

   // The divisor's high byte arrives on the start edge, so feed next-state operands
   divider_core u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend_d),
      .divisor   (divisor_d),
      .busy      (core_busy),
      .done      (core_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_comb begin
      out = '0;
      unique case (sel_e'(select))
         SEL_QUO_LO: out = quotient[BYTEW-1:0];
         SEL_QUO_HI: out = quotient[OPW-1:BYTEW];
         SEL_REM_LO: out = remainder[BYTEW-1:0];
         SEL_REM_HI: out = remainder[OPW-1:BYTEW];
         default:    out = '0;
      endcase
   end

   assign setled     = set;
   assign unlockled  = unlock;
   assign select0led = select[0];
   assign select1led = select[1];
   assign busyled    = core_busy;
   assign doneled    = (state_q == ST_DONE);
   assign errled     = err_q;

endmodule

// File: tb/tb_divider_controller.sv
// Randomized self-checking bench for divider_controller against a plain-arithmetic model.
module tb_divider_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] inp;
   logic       set;
   logic       unlock;
   logic [1:0] select;
   logic [7:0] out;
   logic       setled, unlockled, select0led, select1led;
   logic       busyled, doneled, errled;

   int errors = 0;
   int checks = 0;

   // Model: the result currently held by the block
   logic [15:0] m_q = '0;
   logic [15:0] m_r = '0;
   logic        m_err = 1'b0;

   always #5 clk = ~clk;

   divider_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inp        (inp),
      .set        (set),
      .unlock     (unlock),
      .select     (select),
      .out        (out),
      .setled     (setled),
      .unlockled  (unlockled),
      .select0led (select0led),
      .select1led (select1led),
      .busyled    (busyled),
      .doneled    (doneled),
      .errled     (errled)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] exp_out(input logic [1:0] s);
      case (s)
         2'd0:    return m_q[7:0];
         2'd1:    return m_q[15:8];
         2'd2:    return m_r[7:0];
         default: return m_r[15:8];
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      inp = b;
      set = 1'b1;
      tick();
      set = 1'b0;
      unlock = 1'b1;
      tick();
      unlock = 1'b0;
   endtask

   task automatic load_first3(input logic [15:0] dd, input logic [15:0] dv);
      load_byte(dd[7:0]);
      load_byte(dd[15:8]);
      load_byte(dv[7:0]);
   endtask

   // Loads the last byte and follows the division to completion
   task automatic finish_division(input logic [15:0] dd, input logic [15:0] dv,
                                  input bit poke, input string tag);
      inp = dv[15:8];
      set = 1'b1;
      tick();
      checks++;
      if (busyled !== 1'b1 || doneled !== 1'b0) begin
         errors++;
         $display("FAIL %s start: busy=%b done=%b required busy=1 done=0", tag, busyled, doneled);
      end
      set = 1'b0;
      unlock = 1'b1;
      tick();
      unlock = 1'b0;
      checks++;
      if (errled !== 1'b0) begin
         errors++;
         $display("FAIL %s err_clear: errled=%b required 0", tag, errled);
      end
      for (int k = 2; k <= 15; k++) begin
         if (poke && k >= 3 && k <= 10) begin
            set = 1'b1;
            inp = 8'($urandom);
            unlock = k[0];
         end else begin
            set = 1'b0;
            unlock = 1'b0;
         end
         select = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if (doneled !== 1'b0 || busyled !== 1'b1 || out !== exp_out(select)) begin
            errors++;
            $display("FAIL %s busy_cycle%0d: busy=%b done=%b out=%h required busy=1 done=0 out=%h",
                     tag, k, busyled, doneled, out, exp_out(select));
         end
      end
      set = 1'b0;
      unlock = 1'b0;
      tick();
      m_q   = (dv == 16'h0) ? 16'hFFFF : dd / dv;
      m_r   = (dv == 16'h0) ? dd : dd % dv;
      m_err = (dv == 16'h0);
      checks++;
      if (doneled !== 1'b1 || busyled !== 1'b0 || errled !== m_err) begin
         errors++;
         $display("FAIL %s done_flags: done=%b busy=%b err=%b required done=1 busy=0 err=%b",
                  tag, doneled, busyled, errled, m_err);
      end
      for (int s = 0; s < 4; s++) begin
         select = 2'(s);
         #1;
         checks++;
         if (out !== exp_out(select)) begin
            errors++;
            $display("FAIL %s result sel=%0d: out=%h required %h (dd=%h dv=%h)",
                     tag, s, out, exp_out(select), dd, dv);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      inp = '0; set = 1'b0; unlock = 1'b0; select = '0;
      #3;
      m_q = '0; m_r = '0; m_err = 1'b0;
      checks++;
      if (busyled !== 1'b0 || doneled !== 1'b0 || errled !== 1'b0) begin
         errors++;
         $display("FAIL reset_leds: busy=%b done=%b err=%b required 0 0 0", busyled, doneled, errled);
      end
      for (int s = 0; s < 4; s++) begin
         select = 2'(s);
         #1;
         checks++;
         if (out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out sel=%0d: out=%h required 00", s, out);
         end
      end
   endtask

   task automatic test_led_copies;
      for (int i = 0; i < 8; i++) begin
         set = 1'($urandom);
         unlock = 1'($urandom);
         select = 2'($urandom);
         #1;
         checks++;
         if (setled !== set || unlockled !== unlock ||
             select0led !== select[0] || select1led !== select[1]) begin
            errors++;
            $display("FAIL led_copy: leds=%b%b%b%b required %b%b%b%b", setled, unlockled,
                     select1led, select0led, set, unlock, select[1], select[0]);
         end
      end
      set = 1'b0; unlock = 1'b0; select = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      load_first3(16'd1000, 16'd7);
      finish_division(16'd1000, 16'd7, 1'b0, "div_1000_7");
   endtask

   task automatic test_max_by_one;
      load_first3(16'hFFFF, 16'h0001);
      finish_division(16'hFFFF, 16'h0001, 1'b0, "div_ffff_1");
   endtask

   task automatic test_div_zero;
      load_first3(16'h1234, 16'h0000);
      finish_division(16'h1234, 16'h0000, 1'b0, "div_by_zero");
      load_first3(16'h00C8, 16'h0009);
      finish_division(16'h00C8, 16'h0009, 1'b0, "after_zero");
   endtask

   task automatic test_lock_and_busy;
      logic [15:0] dd, dv;
      dd = 16'($urandom);
      dv = 16'($urandom_range(1, 65535));
      inp = dd[7:0];
      set = 1'b1;
      tick();
      checks++;
      if (doneled !== 1'b0) begin
         errors++;
         $display("FAIL done_exit: doneled=%b required 0", doneled);
      end
      for (int i = 1; i < 10; i++) begin
         inp = 8'($urandom);
         tick();
      end
      set = 1'b0;
      unlock = 1'b1;
      tick();
      unlock = 1'b0;
      load_byte(dd[15:8]);
      load_byte(dv[7:0]);
      checks++;
      if (busyled !== 1'b0) begin
         errors++;
         $display("FAIL held_set_count: busyled=%b required 0 after three loads", busyled);
      end
      finish_division(dd, dv, 1'b1, "held_set_poke");
      dd = 16'($urandom);
      dv = 16'($urandom_range(1, 300));
      load_first3(dd, dv);
      finish_division(dd, dv, 1'b0, "after_poke");
   endtask

   task automatic test_reset_mid;
      load_first3(16'd1000, 16'd7);
      inp = 8'h00;
      set = 1'b1;
      tick();
      set = 1'b0;
      unlock = 1'b1;
      tick();
      unlock = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      m_q = '0; m_r = '0; m_err = 1'b0;
      checks++;
      if (busyled !== 1'b0 || doneled !== 1'b0 || errled !== 1'b0) begin
         errors++;
         $display("FAIL midreset_leds: busy=%b done=%b err=%b required 0 0 0", busyled, doneled, errled);
      end
      for (int s = 0; s < 4; s++) begin
         select = 2'(s);
         #1;
         checks++;
         if (out !== 8'h00) begin
            errors++;
            $display("FAIL midreset_out sel=%0d: out=%h required 00", s, out);
         end
      end
      tick();
      tick();
      rst_n = 1'b1;
      load_first3(16'd1000, 16'd7);
      finish_division(16'd1000, 16'd7, 1'b0, "after_midreset");
   endtask

   task automatic test_random;
      logic [15:0] dd, dv;
      for (int n = 0; n < 8; n++) begin
         dd = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       dv = 16'h0000;
            1:       dv = 16'($urandom_range(1, 255));
            default: dv = 16'($urandom);
         endcase
         load_first3(dd, dv);
         finish_division(dd, dv, ($urandom_range(0, 1) == 1), "random");
      end
   endtask

   initial begin
      test_reset();
      test_led_copies();
      test_basic();
      test_max_by_one();
      test_div_zero();
      test_lock_and_busy();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
